// File: rtl/addsub_pkg.sv
// Shared constants for the pg_addsub_pipe pipelined adder/subtractor:
// operation encodings and the default carry-lookahead group size.
package addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int GROUP_DEFAULT = 4;

endpackage

// File: rtl/pg_gen.sv
// Combinational bitwise propagate/generate for an add or subtract.
// On subtract b is inverted here; the +1 enters as the carry-in of the lookahead.
module pg_gen
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] g
);

    logic [WIDTH-1:0] b_eff;

    assign b_eff = b ^ {WIDTH{op == OP_SUB}};
    assign p     = a ^ b_eff;
    assign g     = a & b_eff;

endmodule

// File: rtl/pg_addsub_pipe.sv
// Two-stage valid/ready add/subtract pipeline with group carry-lookahead.
// Define SATURATE_EN to clamp signed-overflow results to the signed max/min.
module pg_addsub_pipe
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GROUP = GROUP_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NGROUPS = WIDTH / GROUP;

    logic [WIDTH-1:0]   p_next;
    logic [WIDTH-1:0]   g_next;
    logic               s1_valid;
    logic               s1_op;
    logic [WIDTH-1:0]   s1_p;
    logic [WIDTH-1:0]   s1_g;
    logic               s2_free;
    logic               s1_advance;
    logic [NGROUPS-1:0] grp_g;
    logic [NGROUPS-1:0] grp_p;
    logic [NGROUPS:0]   grp_c;
    logic [WIDTH:0]     carry;
    logic [WIDTH-1:0]   raw_sum;
    logic [WIDTH-1:0]   sum_next;
    logic               ovf_next;

    pg_gen #(.WIDTH(WIDTH)) u_pg_gen (
        .op (op),
        .a  (a),
        .b  (b),
        .p  (p_next),
        .g  (g_next)
    );

    assign s2_free    = !out_valid || out_ready;
    assign s1_advance = s1_valid && s2_free;
    assign in_ready   = !s1_valid || s1_advance;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= 1'b0;
            s1_p     <= '0;
            s1_g     <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_op <= op;
                s1_p  <= p_next;
                s1_g  <= g_next;
            end
        end
    end

    // Group G/P, then group carries chained from the carry-in, then per-bit carries inside each group.
    always_comb begin
        grp_g = '0;
        grp_p = '0;
        grp_c = '0;
        carry = '0;
        for (int k = 0; k < NGROUPS; k++) begin
            grp_p[k] = &s1_p[k*GROUP +: GROUP];
            for (int j = 0; j < GROUP; j++) begin
                grp_g[k] = s1_g[k*GROUP+j] | (s1_p[k*GROUP+j] & grp_g[k]);
            end
        end
        grp_c[0] = s1_op;
        for (int k = 0; k < NGROUPS; k++) begin
            grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
        end
        for (int k = 0; k < NGROUPS; k++) begin
            carry[k*GROUP] = grp_c[k];
            for (int j = 1; j < GROUP; j++) begin
                carry[k*GROUP+j] = s1_g[k*GROUP+j-1] | (s1_p[k*GROUP+j-1] & carry[k*GROUP+j-1]);
            end
        end
        carry[WIDTH] = grp_c[NGROUPS];
    end

    assign raw_sum  = s1_p ^ carry[WIDTH-1:0];
    assign ovf_next = carry[WIDTH-1] ^ carry[WIDTH];

`ifdef SATURATE_EN
    // A set sign bit on overflow means the true result was positive, so clamp to max.
    always_comb begin
        sum_next = raw_sum;
        if (ovf_next) begin
            sum_next = raw_sum[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                        : {1'b1, {(WIDTH-1){1'b0}}};
        end
    end
`else
    assign sum_next = raw_sum;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else if (s2_free) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                sum  <= sum_next;
                cout <= carry[WIDTH];
                ovf  <= ovf_next;
                zero <= (sum_next == '0);
            end
        end
    end

endmodule

// File: tb/tb_pg_addsub_pipe.sv
// Bench for pg_addsub_pipe: three widths/group sizes share one handshake and
// are compared against an arithmetic reference model and directed vectors.
module tb_pg_addsub_pipe;
    import addsub_pkg::*;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        int          e;
    } beat_t;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        op = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] a = '0;
    logic [31:0] b = '0;

    logic        in_ready16, out_valid16, cout16, ovf16, zero16;
    logic [15:0] sum16;
    logic        in_ready8, out_valid8, cout8, ovf8, zero8;
    logic [7:0]  sum8;
    logic        in_ready32, out_valid32, cout32, ovf32, zero32;
    logic [31:0] sum32;

    int vectors = 0;
    int miscompares = 0;
    int edge_cnt = 0;
    beat_t q[$];

    logic [15:0] da [4] = '{16'hFFFF, 16'h7FFF, 16'h0000, 16'h0005};
    logic [15:0] db [4] = '{16'h0001, 16'h0001, 16'h0001, 16'h0005};
    logic        dop[4] = '{OP_ADD, OP_ADD, OP_SUB, OP_SUB};
`ifdef SATURATE_EN
    logic [15:0] ds [4] = '{16'h0000, 16'h7FFF, 16'hFFFF, 16'h0000};
`else
    logic [15:0] ds [4] = '{16'h0000, 16'h8000, 16'hFFFF, 16'h0000};
`endif
    logic        dc [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic        dv [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic        dz [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    pg_addsub_pipe #(.WIDTH(16), .GROUP(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
        .a(a[15:0]), .b(b[15:0]), .op(op), .out_valid(out_valid16), .out_ready(out_ready),
        .sum(sum16), .cout(cout16), .ovf(ovf16), .zero(zero16)
    );

    pg_addsub_pipe #(.WIDTH(8), .GROUP(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
        .a(a[7:0]), .b(b[7:0]), .op(op), .out_valid(out_valid8), .out_ready(out_ready),
        .sum(sum8), .cout(cout8), .ovf(ovf8), .zero(zero8)
    );

    pg_addsub_pipe #(.WIDTH(32), .GROUP(8)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
        .a(a), .b(b), .op(op), .out_valid(out_valid32), .out_ready(out_ready),
        .sum(sum32), .cout(cout32), .ovf(ovf32), .zero(zero32)
    );

    // Reference: exact integer arithmetic on the operands as unsigned and signed values.
    function automatic res_t calc(input int w, input logic [31:0] a_in, input logic [31:0] b_in,
                                  input logic op_in);
        longint m, ua, ub, sa, sb, r, full, mx, mn;
        res_t res;
        m    = (longint'(1) << w) - 1;
        mx   = (longint'(1) << (w - 1)) - 1;
        mn   = -(mx + 1);
        ua   = longint'({32'd0, a_in}) & m;
        ub   = longint'({32'd0, b_in}) & m;
        sa   = (ua > mx) ? ua - (m + 1) : ua;
        sb   = (ub > mx) ? ub - (m + 1) : ub;
        r    = op_in ? sa - sb : sa + sb;
        full = op_in ? ua - ub : ua + ub;
        res.sum  = 32'(full & m);
        res.cout = op_in ? (ua >= ub) : (full > m);
        res.ovf  = (r > mx) || (r < mn);
`ifdef SATURATE_EN
        if (res.ovf) res.sum = 32'((r > mx) ? mx : (mn & m));
`endif
        res.zero = (res.sum == 32'd0);
        return res;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h0000_0001;
            3:       return 32'h7F7F_7FFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if ({in_ready16, out_valid16, sum16, cout16, ovf16, zero16} !== {1'b1, 1'b0, 16'h0, 3'b000}) begin
            miscompares++;
            $display("[TB] FAIL reset16 got ir=%b ov=%b sum=%h c=%b v=%b z=%b exp ir=1 ov=0 sum=0 c=0 v=0 z=0",
                     in_ready16, out_valid16, sum16, cout16, ovf16, zero16);
        end
        vectors++;
        if ({out_valid8, out_valid32, sum8, sum32} !== 42'd0) begin
            miscompares++;
            $display("[TB] FAIL reset8_32 got ov8=%b ov32=%b sum8=%h sum32=%h exp all 0",
                     out_valid8, out_valid32, sum8, sum32);
        end
        #1;
        rst_n = 1'b1;
        in_valid = 1'b1; a = 32'd3; b = 32'd4; op = OP_ADD; out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready16 !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL first_beat_ready got %b exp 1", in_ready16);
        end
        @(negedge clk);
        in_valid = 1'b0;
        vectors++;
        if (out_valid16 !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL first_beat_early got ov=%b exp 0", out_valid16);
        end
        @(negedge clk);
        vectors++;
        if ({out_valid16, sum16, out_valid8, sum8, out_valid32, sum32} !== {1'b1, 16'd7, 1'b1, 8'd7, 1'b1, 32'd7}) begin
            miscompares++;
            $display("[TB] FAIL first_beat got ov=%b%b%b sums=%h/%h/%h exp ov=111 sums=7",
                     out_valid16, out_valid8, out_valid32, sum16, sum8, sum32);
        end
    endtask

    task automatic test_directed();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = {16'h0, da[i]}; b = {16'h0, db[i]}; op = dop[i]; out_ready = 1'b1;
            #1;
            vectors++;
            if (in_ready16 !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL dir%0d_ready got %b exp 1", i, in_ready16);
            end
            @(negedge clk);
            in_valid = 1'b0;
            vectors++;
            if (out_valid16 !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL dir%0d_latency got ov=%b exp 0", i, out_valid16);
            end
            @(negedge clk);
            vectors++;
            if ({out_valid16, sum16, cout16, ovf16, zero16} !== {1'b1, ds[i], dc[i], dv[i], dz[i]}) begin
                miscompares++;
                $display("[TB] FAIL dir%0d got ov=%b sum=%h c=%b v=%b z=%b exp ov=1 sum=%h c=%b v=%b z=%b",
                         i, out_valid16, sum16, cout16, ovf16, zero16, ds[i], dc[i], dv[i], dz[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [15:0] ba [3];
        logic [15:0] bb [3];
        logic        bo [3];
        res_t        r;
        int          exp_idx [8] = '{-1, -1, 0, 0, 0, 1, 2, -1};
        logic        exp_ir  [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            ba[i] = 16'($urandom);
            bb[i] = 16'($urandom);
            bo[i] = 1'($urandom_range(1));
        end
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            vectors++;
            if (out_valid16 !== (exp_idx[n] >= 0)) begin
                miscompares++;
                $display("[TB] FAIL bp_valid cyc%0d got %b exp %b", n, out_valid16, exp_idx[n] >= 0);
            end
            if (exp_idx[n] >= 0) begin
                r = calc(16, {16'h0, ba[exp_idx[n]]}, {16'h0, bb[exp_idx[n]]}, bo[exp_idx[n]]);
                vectors++;
                if ({sum16, cout16, ovf16, zero16} !== {r.sum[15:0], r.cout, r.ovf, r.zero}) begin
                    miscompares++;
                    $display("[TB] FAIL bp_data cyc%0d got sum=%h c=%b v=%b z=%b exp sum=%h c=%b v=%b z=%b",
                             n, sum16, cout16, ovf16, zero16, r.sum[15:0], r.cout, r.ovf, r.zero);
                end
            end
            in_valid  = (n < 5);
            a         = {16'h0, ba[(n < 2) ? n : 2]};
            b         = {16'h0, bb[(n < 2) ? n : 2]};
            op        = bo[(n < 2) ? n : 2];
            out_ready = (n >= 4);
            #1;
            vectors++;
            if (in_ready16 !== exp_ir[n]) begin
                miscompares++;
                $display("[TB] FAIL bp_ready cyc%0d got %b exp %b", n, in_ready16, exp_ir[n]);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_in_flight();
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            in_valid = 1'b1; a = pick(); b = pick(); op = 1'($urandom_range(1)); out_ready = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        vectors++;
        if (out_valid16 !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL flight_full got ov=%b exp 1", out_valid16);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({out_valid16, out_valid8, out_valid32, in_ready16, sum16, zero16} !== {3'b000, 1'b1, 16'h0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL flight_reset got ov=%b%b%b ir=%b sum=%h z=%b exp ov=000 ir=1 sum=0 z=0",
                     out_valid16, out_valid8, out_valid32, in_ready16, sum16, zero16);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            vectors++;
            if ({out_valid16, out_valid8, out_valid32} !== 3'b000) begin
                miscompares++;
                $display("[TB] FAIL flight_stale cyc%0d got ov=%b%b%b exp 000",
                         n, out_valid16, out_valid8, out_valid32);
            end
        end
    endtask

    task automatic test_random();
        int    accepted = 0;
        int    cycles = 0;
        logic  exp_v, exp_r;
        res_t  r16, r8, r32;
        beat_t bt;
        q.delete();
        while ((accepted < 1000 || q.size() > 0) && cycles < 8000) begin
            @(negedge clk);
            cycles++;
            exp_v = (q.size() > 0) && (q[0].e + 2 <= edge_cnt);
            vectors++;
            if ({out_valid16, out_valid8, out_valid32} !== {3{exp_v}}) begin
                miscompares++;
                $display("[TB] FAIL rnd_valid cyc%0d got %b%b%b exp %b", cycles,
                         out_valid16, out_valid8, out_valid32, exp_v);
            end
            if (exp_v) begin
                r16 = calc(16, q[0].a, q[0].b, q[0].op);
                r8  = calc(8,  q[0].a, q[0].b, q[0].op);
                r32 = calc(32, q[0].a, q[0].b, q[0].op);
                vectors++;
                if ({sum16, cout16, ovf16, zero16} !== {r16.sum[15:0], r16.cout, r16.ovf, r16.zero}) begin
                    miscompares++;
                    $display("[TB] FAIL rnd_data16 cyc%0d got sum=%h c=%b v=%b z=%b exp sum=%h c=%b v=%b z=%b",
                             cycles, sum16, cout16, ovf16, zero16, r16.sum[15:0], r16.cout, r16.ovf, r16.zero);
                end
                vectors++;
                if ({sum8, cout8, ovf8, zero8} !== {r8.sum[7:0], r8.cout, r8.ovf, r8.zero}) begin
                    miscompares++;
                    $display("[TB] FAIL rnd_data8 cyc%0d got sum=%h c=%b v=%b z=%b exp sum=%h c=%b v=%b z=%b",
                             cycles, sum8, cout8, ovf8, zero8, r8.sum[7:0], r8.cout, r8.ovf, r8.zero);
                end
                vectors++;
                if ({sum32, cout32, ovf32, zero32} !== {r32.sum, r32.cout, r32.ovf, r32.zero}) begin
                    miscompares++;
                    $display("[TB] FAIL rnd_data32 cyc%0d got sum=%h c=%b v=%b z=%b exp sum=%h c=%b v=%b z=%b",
                             cycles, sum32, cout32, ovf32, zero32, r32.sum, r32.cout, r32.ovf, r32.zero);
                end
            end
            in_valid  = (accepted < 1000) && ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            op        = 1'($urandom_range(1));
            a         = pick();
            b         = pick();
            #1;
            exp_r = (q.size() < 2) || out_ready;
            vectors++;
            if ({in_ready16, in_ready8, in_ready32} !== {3{exp_r}}) begin
                miscompares++;
                $display("[TB] FAIL rnd_ready cyc%0d got %b%b%b exp %b", cycles,
                         in_ready16, in_ready8, in_ready32, exp_r);
            end
            if (exp_v && out_ready) void'(q.pop_front());
            if (in_valid && exp_r) begin
                bt.a = a; bt.b = b; bt.op = op; bt.e = edge_cnt;
                q.push_back(bt);
                accepted++;
            end
        end
        in_valid = 1'b0;
        vectors++;
        if (accepted < 1000 || q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL rnd_budget got accepted=%0d pending=%0d exp accepted=1000 pending=0",
                     accepted, q.size());
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_in_flight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pg_addsub_pipe.md
PG_ADDSUB_PIPE -- requirements
Module: pg_addsub_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning operand/result width in bits; legal values are 4..64 and a multiple of GROUP.
REQ-002 The block SHALL have parameter GROUP, default 4, meaning carry-lookahead group size in bits.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid  input  1  operand beat present.
REQ-006 The block SHALL have port in_ready  output  1  block accepts a beat this cycle.
REQ-007 The block SHALL have ports a, b  input  WIDTH  operands.
REQ-008 The block SHALL have port op  input  1  0 = add (a+b), 1 = subtract (a-b).
REQ-009 The block SHALL have port out_valid  output  1  result beat present.
REQ-010 The block SHALL have port out_ready  input  1  consumer takes the result beat.
REQ-011 The block SHALL have port sum  output  WIDTH  result.
REQ-012 The block SHALL have ports cout, ovf, zero  output  1 each  carry-out (no-borrow on subtract), signed overflow, result-is-zero.

Function
REQ-013 A beat SHALL be accepted when in_valid && in_ready, and a result SHALL be delivered when out_valid && out_ready.
REQ-014 Stage 1 SHALL register op, p = a ^ b', g = a & b', where b' = b ^ {WIDTH{op}} and carry-in = op.
REQ-015 Stage 2 SHALL compute group generate/propagate per GROUP bits, lookahead carries across groups, sum = p ^ carries, and register sum, cout, ovf, zero.
REQ-016 Latency SHALL be 2 cycles from acceptance to out_valid with no stall; throughput SHALL be 1 beat/cycle.
REQ-017 Each stage SHALL advance when it is empty or the downstream stage advances in the same cycle; in_ready = !s1_valid || s1_advance.
REQ-018 Simultaneous accept and deliver with both stages full SHALL move all beats one stage with no bubble and no loss.
REQ-019 While out_valid && !out_ready, sum/cout/ovf/zero SHALL hold stable.
REQ-020 Results SHALL emerge in acceptance order.
REQ-021 cout SHALL be the carry out of bit WIDTH-1: on subtract, 1 iff a >= b unsigned.
REQ-022 ovf SHALL be carry-into-MSB XOR carry-out-of-MSB; zero SHALL be 1 iff the delivered sum == 0.

Reset
REQ-023 On rst_n low, s1_valid, out_valid, sum, cout, ovf and zero SHALL clear to 0 immediately, in_ready SHALL read 1, and in-flight beats SHALL be discarded.
REQ-024 The first beat after rst_n deasserts SHALL be acceptable on the first rising edge.

Configuration
REQ-025 With SATURATE_EN defined, a result with ovf=1 SHALL be clamped to the signed maximum (positive overflow) or signed minimum (negative overflow); ovf SHALL still read 1 and zero SHALL reflect the clamped value.
REQ-026 Without SATURATE_EN, sum SHALL wrap modulo 2^WIDTH and no clamp logic SHALL be present.

Structure
REQ-027 Package addsub_pkg SHALL hold the op encodings OP_ADD=0 and OP_SUB=1, plus the GROUP default constant.
REQ-028 Sub-module pg_gen SHALL be the parametrised combinational WIDTH-bit p/g generator instantiated in stage 1; the lookahead logic stays in the top module.

Verification
REQ-029 For WIDTH=16, add 0xFFFF+0x0001 SHALL give sum=0x0000, cout=1, zero=1, ovf=0, with out_valid 2 cycles after acceptance.
REQ-030 For WIDTH=16, add 0x7FFF+0x0001 SHALL give ovf=1 and cout=0, with sum=0x8000 without SATURATE_EN and sum=0x7FFF with it.
REQ-031 Subtract 0x0000-0x0001 SHALL give sum=0xFFFF, cout=0, ovf=0; subtract 0x0005-0x0005 SHALL give sum=0x0000, cout=1, zero=1.
REQ-032 Backpressure: with 3 beats sent back-to-back and out_ready low for 4 cycles, in_ready SHALL drop after 2 beats are held, outputs SHALL stay stable, and the results SHALL deliver in order once out_ready rises.
REQ-033 rst_n pulsed low with 2 beats in flight SHALL clear out_valid immediately, and no stale result SHALL appear after release.
REQ-034 A 1000-beat random sweep with random out_ready, at WIDTH in {8,16,32} and GROUP in {4,8}, SHALL match a reference model.
